compare8_arb: RTL and testbench

Round-robin controller that shares one `compare8` 8-bit unsigned magnitude comparator among `N_REQ` requesters. It arbitrates pending requests and latches the winner's operands into the comparator. It then registers the comparator outputs and returns them to the winner with a one-cycle acknowledge pulse. It sits between client blocks that need occasional comparisons and the single `compare8` instance.

---
 rtl/compare_pkg.sv | 6 +
 rtl/compare8.sv | 14 +
 rtl/compare8_arb.sv | 85 ++++++++
 tb/tb_compare8_arb.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// compare_pkg: shared state encoding and sizing for the compare8 arbiter
package compare_pkg;
  localparam int CMP_W = 8;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, ACK = 2'd2} state_t;
endpackage

// File: rtl/compare8.sv
// compare8: unsigned magnitude comparator, one-hot gt/lt/eq
module compare8
  import compare_pkg::*;
(
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  output logic             re,
  output logic             reb,
  output logic             eq
);
  assign re  = a > b;
  assign reb = a < b;
  assign eq  = a == b;
endmodule

// File: rtl/compare8_arb.sv
// compare8_arb: round-robin sharing of one compare8 among N_REQ requesters
module compare8_arb
  import compare_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [CMP_W*N_REQ-1:0] a_bus,
  input  logic [CMP_W*N_REQ-1:0] b_bus,
  output logic [N_REQ-1:0]       ack,
  output logic                   res_gt,
  output logic                   res_lt,
  output logic                   res_eq,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);
  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, cur_id, win;
  logic [CMP_W-1:0]  op_a, op_b;
  logic              grant, done, re, reb, eq;

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W-1:0] w;
    logic            found;
    int              k;
    w = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(p) + i) % N_REQ;
      if (!found && r[k]) begin
        w = ID_W'(k);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win  = rr_pick(req, ptr);
  assign busy = state != IDLE;

  compare8 u_cmp (.a(op_a), .b(op_b), .re(re), .reb(reb), .eq(eq));

  // State register
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // Next state: grant only from IDLE, CMP always closes into ACK, everything else returns to IDLE
  always_comb begin
    grant   = state == IDLE && |req;
    done    = state == CMP;
    state_n = grant ? CMP : done ? ACK : IDLE;
  end

  // Operand latch, pointer advance, result registers and the one-cycle ack pulse
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      cur_id <= '0;
      ptr    <= '0;
      res_gt <= 1'b0;
      res_lt <= 1'b0;
      res_eq <= 1'b0;
      res_id <= '0;
      ack    <= '0;
    end else begin
      if (grant) begin
        op_a   <= a_bus[CMP_W*win +: CMP_W];
        op_b   <= b_bus[CMP_W*win +: CMP_W];
        cur_id <= win;
        ptr    <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
      end
      if (done) begin
        res_gt <= re;
        res_lt <= reb;
        res_eq <= eq;
        res_id <= cur_id;
      end
      ack <= done ? N_REQ'(1) << cur_id : '0;
    end
endmodule

// File: tb/tb_compare8_arb.sv
// tb_compare8_arb: directed and random checks of compare8_arb against a round-robin model
module tb_compare8_arb;
  localparam int N = 4;
  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic [7:0]   ma [N];
  logic [7:0]   mb [N];
  logic [8*N-1:0] a_bus, b_bus;
  logic         res_gt, res_lt, res_eq, busy;
  logic [1:0]   res_id;
  int           n_chk = 0;
  int           n_fail = 0;
  int           ptr_m = 0;

  always #5 clock = ~clock;

  assign a_bus = {ma[3], ma[2], ma[1], ma[0]};
  assign b_bus = {mb[3], mb[2], mb[1], mb[0]};

  compare8_arb #(.N_REQ(N)) dut (
    .clock(clock), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq),
    .res_id(res_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  function automatic int mpick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Called in an IDLE cycle with req already driven; walks CMP, ACK and the following IDLE
  task automatic txn(input string tag);
    int         w;
    logic [7:0] ea, eb;
    w  = mpick(req, ptr_m);
    ea = ma[w];
    eb = mb[w];
    tick;
    chk({tag, ".cmp_busy"}, 32'(busy), 32'd1);
    chk({tag, ".cmp_ack"}, 32'(ack), 32'd0);
    ma[w] = 8'($urandom);
    mb[w] = 8'($urandom);
    tick;
    chk({tag, ".ack"}, 32'(ack), 32'(4'b0001 << w));
    chk({tag, ".flags"}, 32'({res_gt, res_lt, res_eq}), 32'({ea > eb, ea < eb, ea == eb}));
    chk({tag, ".id"}, 32'(res_id), 32'(w));
    chk({tag, ".ack_busy"}, 32'(busy), 32'd1);
    req[w] = 1'b0;
    ma[w]  = ea;
    mb[w]  = eb;
    tick;
    chk({tag, ".idle_ack"}, 32'(ack), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".hold_id"}, 32'(res_id), 32'(w));
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    logic [N-1:0] nr;
    for (int i = 0; i < N; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    repeat (3) tick;
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.flags", 32'({res_gt, res_lt, res_eq}), 32'd0);
    chk("rst.id", 32'(res_id), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.ack", 32'(ack), 32'd0);

    for (int i = 0; i < N; i++) begin
      ma[i] = 8'($urandom);
      mb[i] = 8'($urandom);
    end
    req = 4'b1111;
    for (int k = 0; k < N; k++) txn("contend");

    req = 4'b1001;
    txn("wrap0");
    txn("wrap3");

    ma[1] = 8'h5A; mb[1] = 8'h3C; req = 4'b0010;
    txn("single");
    ma[2] = 8'hFF; mb[2] = 8'hFF; req = 4'b0100;
    txn("eq_ff");
    ma[2] = 8'h00; mb[2] = 8'h80; req = 4'b0100;
    txn("lt_00_80");
    ma[2] = 8'h80; mb[2] = 8'h7F; req = 4'b0100;
    txn("gt_80_7f");

    ma[1] = 8'h11; mb[1] = 8'h22; req = 4'b0010;
    tick;
    chk("midrst.cmp_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ack", 32'(ack), 32'd0);
    chk("midrst.flags", 32'({res_gt, res_lt, res_eq}), 32'd0);
    chk("midrst.id", 32'(res_id), 32'd0);
    req = '0;
    tick;
    tick;
    chk("midrst.no_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    ptr_m = 0;
    tick;
    chk("midrst.idle", 32'(busy), 32'd0);
    ma[2] = 8'h40; mb[2] = 8'h41; req = 4'b0110;
    txn("post_rst1");
    txn("post_rst2");

    repeat (40) begin
      nr = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if (nr[i] && !req[i]) begin
          ma[i] = 8'($urandom);
          mb[i] = ($urandom_range(0, 3) == 0) ? ma[i] : 8'($urandom);
        end
      req = req | nr;
      if (req == '0) begin
        tick;
        chk("rand.idle_busy", 32'(busy), 32'd0);
        chk("rand.idle_ack", 32'(ack), 32'd0);
      end else txn("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
